// File: rtl/alu_seq.sv
// Microcode sequencer for the 4-bit ALU: loads X1/X2/X3 over the shared bus,
// waits out execution, then reads back the result and optionally the flags.
module alu_seq #(
    parameter int DATA_W      = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              no_flags,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] op_in,
    input  logic [DATA_W-1:0] bus_in,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        rs,
    output logic [1:0]        ws,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] flags
);

    typedef enum logic [2:0] {
        IDLE, LD_A, LD_B, LD_OP, EXEC, RD_RES, RD_FLG, DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t            state, state_nx;
    logic [DATA_W-1:0] a_q, b_q, op_q;
    logic              nf_q;
    logic [3:0]        cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            nf_q   <= 1'b0;
            cnt    <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            if (state == IDLE && req) begin
                a_q  <= a_in;
                b_q  <= b_in;
                op_q <= op_in;
                nf_q <= no_flags;
            end
            // Counter is loaded on the way into EXEC so EXEC exits when it reaches 0.
            if (state == LD_OP)
                cnt <= CNT_LOAD;
            else if (state == EXEC && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == RD_RES) result <= bus_in;
            if (state == RD_FLG) flags  <= bus_in;
        end
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        rs       = 2'b00;
        ws       = 2'b00;
        bus_out  = '0;
        bus_oe   = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (req) state_nx = LD_A;
            end
            LD_A: begin
                rs       = 2'b01;
                bus_out  = a_q;
                bus_oe   = 1'b1;
                state_nx = LD_B;
            end
            LD_B: begin
                rs       = 2'b10;
                bus_out  = b_q;
                bus_oe   = 1'b1;
                state_nx = LD_OP;
            end
            LD_OP: begin
                rs       = 2'b11;
                bus_out  = op_q;
                bus_oe   = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                if (cnt == 4'd0) state_nx = RD_RES;
            end
            RD_RES: begin
                ws       = 2'b01;
                state_nx = nf_q ? DONE : RD_FLG;
            end
            RD_FLG: begin
                ws       = 2'b10;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
